pc_src_reg: RTL and testbench

PC_SRC_REG -- requirements
Module: pc_src_reg

---
 rtl/pc_src_pkg.sv | 19 +
 rtl/mux_n.sv | 19 +
 rtl/pc_src_reg.sv | 87 ++++++++
 tb/tb_pc_src_reg.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/pc_src_pkg.sv
// Shared defaults and source-index constants for the PC source register.
package pc_src_pkg;

  localparam int unsigned DEF_WIDTH       = 32;
  localparam int unsigned DEF_NUM_SRC     = 4;
  localparam int unsigned DEF_RESET_PC    = 0;
  localparam bit          DEF_FORCE_ALIGN = 1'b1;
  localparam int unsigned DEF_CNT_W       = 16;

  localparam int unsigned SRC_ALU     = 0;
  localparam int unsigned SRC_ALU_RES = 1;
  localparam int unsigned SRC_A_OUT   = 2;
  localparam int unsigned SRC_CONCAT  = 3;

  function automatic int unsigned sel_width(input int unsigned n);
    return (n > 2) ? unsigned'($clog2(n)) : 1;
  endfunction

endpackage

// File: rtl/mux_n.sv
// N-way combinational source mux; an out-of-range select yields zero.
module mux_n #(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned NUM_SRC = 4,
  parameter int unsigned SEL_W   = 2
) (
  input  logic [NUM_SRC*WIDTH-1:0] src,
  input  logic [SEL_W-1:0]         sel,
  output logic [WIDTH-1:0]         out
);

  always_comb begin
    out = '0;
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      if (32'(sel) == i) out = src[i*WIDTH +: WIDTH];
    end
  end

endmodule

// File: rtl/pc_src_reg.sv
// Program counter register with selectable next-PC source, branch-conditional
// update, sticky bad-select flag and saturating update counter.
module pc_src_reg
  import pc_src_pkg::*;
#(
  parameter int unsigned      WIDTH       = DEF_WIDTH,
  parameter int unsigned      NUM_SRC     = DEF_NUM_SRC,
  parameter logic [WIDTH-1:0] RESET_PC    = WIDTH'(DEF_RESET_PC),
  parameter bit               FORCE_ALIGN = DEF_FORCE_ALIGN,
  parameter int unsigned      CNT_W       = DEF_CNT_W,
  localparam int unsigned     SEL_W       = sel_width(NUM_SRC)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_SRC*WIDTH-1:0] src,
  input  logic [SEL_W-1:0]         sel,
  input  logic                     pc_write,
  input  logic                     pc_write_cond,
  input  logic                     zero,
  input  logic                     branch_ne,
  input  logic                     sel_err_clr,
  output logic [WIDTH-1:0]         pc,
  output logic [WIDTH-1:0]         pc_prev,
  output logic                     pc_updated,
  output logic                     sel_err,
  output logic [CNT_W-1:0]         update_count
);

  localparam logic [WIDTH-1:0] RESET_PC_AL =
    FORCE_ALIGN ? {RESET_PC[WIDTH-1:2], 2'b00} : RESET_PC;

  logic [WIDTH-1:0] mux_out, pc_d, pc_q, pc_prev_d, pc_prev_q;
  logic [CNT_W-1:0] cnt_d, cnt_q;
  logic             upd_q, err_d, err_q;
  logic             req, sel_ok, accept;

  mux_n #(
    .WIDTH   (WIDTH),
    .NUM_SRC (NUM_SRC),
    .SEL_W   (SEL_W)
  ) u_mux (
    .src (src),
    .sel (sel),
    .out (mux_out)
  );

  // Taken branch when zero disagrees with the inverted sense (bne).
  assign req    = pc_write | (pc_write_cond & (zero ^ branch_ne));
  assign sel_ok = 32'(sel) < NUM_SRC;
  assign accept = req & sel_ok;

  always_comb begin
    pc_d      = pc_q;
    pc_prev_d = pc_prev_q;
    cnt_d     = cnt_q;
    if (accept) begin
      pc_d      = FORCE_ALIGN ? {mux_out[WIDTH-1:2], 2'b00} : mux_out;
      pc_prev_d = pc_q;
      if (cnt_q != '1) cnt_d = cnt_q + 1'b1;
    end
    // A fresh error wins over a simultaneous clear.
    err_d = (req & ~sel_ok) | (err_q & ~sel_err_clr);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q      <= RESET_PC_AL;
      pc_prev_q <= RESET_PC;
      upd_q     <= 1'b0;
      err_q     <= 1'b0;
      cnt_q     <= '0;
    end else begin
      pc_q      <= pc_d;
      pc_prev_q <= pc_prev_d;
      upd_q     <= accept;
      err_q     <= err_d;
      cnt_q     <= cnt_d;
    end
  end

  assign pc           = pc_q;
  assign pc_prev      = pc_prev_q;
  assign pc_updated   = upd_q;
  assign sel_err      = err_q;
  assign update_count = cnt_q;

endmodule

// File: tb/tb_pc_src_reg.sv
// Directed bench for pc_src_reg: default, three-source and 2-bit-counter instances.
module tb_pc_src_reg;
  import pc_src_pkg::*;

  localparam int unsigned W = 32;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic [4*W-1:0] src = '0;
  logic [1:0]   sel = '0;
  logic         pc_write = 1'b0, pc_write_cond = 1'b0, zero = 1'b0, branch_ne = 1'b0;
  logic         sel_err_clr = 1'b0;

  logic [W-1:0] pc0, prev0, pc3, prev3, pcc, prevc;
  logic         upd0, err0, upd3, err3, updc, errc;
  logic [15:0]  cnt0, cnt3;
  logic [1:0]   cntc;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pc_src_reg u_d0 (
    .clk (clk), .rst_n (rst_n), .src (src), .sel (sel), .pc_write (pc_write),
    .pc_write_cond (pc_write_cond), .zero (zero), .branch_ne (branch_ne),
    .sel_err_clr (sel_err_clr), .pc (pc0), .pc_prev (prev0), .pc_updated (upd0),
    .sel_err (err0), .update_count (cnt0)
  );

  pc_src_reg #(.NUM_SRC (3)) u_d3 (
    .clk (clk), .rst_n (rst_n), .src (src[3*W-1:0]), .sel (sel), .pc_write (pc_write),
    .pc_write_cond (pc_write_cond), .zero (zero), .branch_ne (branch_ne),
    .sel_err_clr (sel_err_clr), .pc (pc3), .pc_prev (prev3), .pc_updated (upd3),
    .sel_err (err3), .update_count (cnt3)
  );

  pc_src_reg #(.CNT_W (2)) u_dc (
    .clk (clk), .rst_n (rst_n), .src (src), .sel (sel), .pc_write (pc_write),
    .pc_write_cond (pc_write_cond), .zero (zero), .branch_ne (branch_ne),
    .sel_err_clr (sel_err_clr), .pc (pcc), .pc_prev (prevc), .pc_updated (updc),
    .sel_err (errc), .update_count (cntc)
  );

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    pc_write = 1'b0; pc_write_cond = 1'b0; zero = 1'b0; branch_ne = 1'b0;
    sel_err_clr = 1'b0; sel = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    @(posedge clk);
    #1 rst_n = 1'b0;
    #2 rst_n = 1'b1;
  endtask

  task automatic test_reset();
    idle_inputs();
    #1 rst_n = 1'b0;
    #1;
    checks++; if (pc0 !== 32'h0) begin errors++; $display("FAIL reset_pc got %h want 0", pc0); end
    checks++; if (prev0 !== 32'h0) begin errors++; $display("FAIL reset_prev got %h want 0", prev0); end
    checks++; if (upd0 !== 1'b0) begin errors++; $display("FAIL reset_upd got %b want 0", upd0); end
    checks++; if (err0 !== 1'b0) begin errors++; $display("FAIL reset_err got %b want 0", err0); end
    checks++; if (cnt0 !== 16'd0) begin errors++; $display("FAIL reset_cnt got %0d want 0", cnt0); end
    cycle();
    rst_n = 1'b1;
  endtask

  task automatic test_write();
    src[1*W +: W] = 32'h0000_1004; sel = 2'(SRC_ALU_RES); pc_write = 1'b1;
    cycle();
    pc_write = 1'b0;
    checks++; if (pc0 !== 32'h1004) begin errors++; $display("FAIL write_pc got %h want 1004", pc0); end
    checks++; if (prev0 !== 32'h0) begin errors++; $display("FAIL write_prev got %h want 0", prev0); end
    checks++; if (upd0 !== 1'b1) begin errors++; $display("FAIL write_upd got %b want 1", upd0); end
    checks++; if (cnt0 !== 16'd1) begin errors++; $display("FAIL write_cnt got %0d want 1", cnt0); end
    cycle();
    checks++; if (upd0 !== 1'b0) begin errors++; $display("FAIL write_pulse_end got %b want 0", upd0); end
    checks++; if (pc0 !== 32'h1004) begin errors++; $display("FAIL write_hold got %h want 1004", pc0); end
  endtask

  task automatic test_branch();
    src[0 +: W] = 32'h40; sel = 2'(SRC_ALU);
    pc_write_cond = 1'b1; zero = 1'b1; branch_ne = 1'b0;
    cycle();
    pc_write_cond = 1'b0;
    checks++; if (pc0 !== 32'h40) begin errors++; $display("FAIL beq_taken_pc got %h want 40", pc0); end
    checks++; if (prev0 !== 32'h1004) begin errors++; $display("FAIL beq_prev got %h want 1004", prev0); end
    cycle();
    src[0 +: W] = 32'h60; pc_write_cond = 1'b1; zero = 1'b0;
    cycle();
    pc_write_cond = 1'b0;
    checks++; if (pc0 !== 32'h40) begin errors++; $display("FAIL beq_not_taken_pc got %h want 40", pc0); end
    checks++; if (upd0 !== 1'b0) begin errors++; $display("FAIL beq_not_taken_upd got %b want 0", upd0); end
    src[0 +: W] = 32'h80; pc_write_cond = 1'b1; zero = 1'b0; branch_ne = 1'b1;
    cycle();
    pc_write_cond = 1'b0; branch_ne = 1'b0;
    checks++; if (pc0 !== 32'h80) begin errors++; $display("FAIL bne_taken_pc got %h want 80", pc0); end
    checks++; if (cnt0 !== 16'd3) begin errors++; $display("FAIL bne_cnt got %0d want 3", cnt0); end
    src[0 +: W] = 32'h88; pc_write = 1'b1; pc_write_cond = 1'b1; zero = 1'b1;
    cycle();
    idle_inputs();
    checks++; if (pc0 !== 32'h88) begin errors++; $display("FAIL both_req_pc got %h want 88", pc0); end
    checks++; if (cnt0 !== 16'd4) begin errors++; $display("FAIL both_req_cnt got %0d want 4", cnt0); end
    cycle();
  endtask

  task automatic test_align();
    src[2*W +: W] = 32'h0000_0107; sel = 2'(SRC_A_OUT); pc_write = 1'b1;
    cycle();
    idle_inputs();
    checks++; if (pc0 !== 32'h104) begin errors++; $display("FAIL align_pc got %h want 104", pc0); end
    checks++; if (pc3 !== 32'h104) begin errors++; $display("FAIL align_pc3 got %h want 104", pc3); end
  endtask

  task automatic test_sel_err();
    do_reset();
    src[3*W +: W] = 32'h2000; sel = 2'(SRC_CONCAT); pc_write = 1'b1;
    cycle();
    checks++; if (pc3 !== 32'h0) begin errors++; $display("FAIL selerr_pc got %h want 0", pc3); end
    checks++; if (err3 !== 1'b1) begin errors++; $display("FAIL selerr_flag got %b want 1", err3); end
    checks++; if (cnt3 !== 16'd0) begin errors++; $display("FAIL selerr_cnt got %0d want 0", cnt3); end
    checks++; if (upd3 !== 1'b0) begin errors++; $display("FAIL selerr_upd got %b want 0", upd3); end
    checks++; if (pc0 !== 32'h2000) begin errors++; $display("FAIL sel3_valid_pc got %h want 2000", pc0); end
    checks++; if (err0 !== 1'b0) begin errors++; $display("FAIL sel3_valid_err got %b want 0", err0); end
    sel_err_clr = 1'b1;
    cycle();
    checks++; if (err3 !== 1'b1) begin errors++; $display("FAIL selerr_clr_vs_new got %b want 1", err3); end
    pc_write = 1'b0;
    cycle();
    checks++; if (err3 !== 1'b0) begin errors++; $display("FAIL selerr_clr got %b want 0", err3); end
    sel_err_clr = 1'b0;
    cycle();
    checks++; if (err3 !== 1'b0) begin errors++; $display("FAIL selerr_no_req got %b want 0", err3); end
    idle_inputs();
  endtask

  task automatic test_back_to_back();
    do_reset();
    sel = 2'(SRC_ALU_RES); pc_write = 1'b1;
    for (int i = 0; i < 5; i++) begin
      src[1*W +: W] = 32'((i + 1) * 32'h100);
      cycle();
      checks++; if (updc !== 1'b1) begin errors++; $display("FAIL b2b_upd[%0d] got %b want 1", i, updc); end
      checks++;
      if (cntc !== 2'((i + 1 > 3) ? 3 : i + 1)) begin
        errors++; $display("FAIL b2b_cnt[%0d] got %0d want %0d", i, cntc, (i + 1 > 3) ? 3 : i + 1);
      end
    end
    pc_write = 1'b0;
    checks++; if (pcc !== 32'h500) begin errors++; $display("FAIL b2b_pc got %h want 500", pcc); end
    checks++; if (cnt0 !== 16'd5) begin errors++; $display("FAIL b2b_cnt16 got %0d want 5", cnt0); end
    cycle();
    checks++; if (updc !== 1'b0) begin errors++; $display("FAIL b2b_pulse_end got %b want 0", updc); end
    checks++; if (cntc !== 2'd3) begin errors++; $display("FAIL b2b_sat_hold got %0d want 3", cntc); end
  endtask

  task automatic test_reset_mid();
    src[1*W +: W] = 32'h3000; sel = 2'(SRC_ALU_RES); pc_write = 1'b1;
    #3 rst_n = 1'b0;
    #1;
    checks++; if (pc0 !== 32'h0) begin errors++; $display("FAIL midrst_pc got %h want 0", pc0); end
    checks++; if (cnt0 !== 16'd0) begin errors++; $display("FAIL midrst_cnt got %0d want 0", cnt0); end
    checks++; if (prev0 !== 32'h0) begin errors++; $display("FAIL midrst_prev got %h want 0", prev0); end
    cycle();
    checks++; if (pc0 !== 32'h0) begin errors++; $display("FAIL midrst_no_update got %h want 0", pc0); end
    rst_n = 1'b1;
    cycle();
    pc_write = 1'b0;
    checks++; if (pc0 !== 32'h3000) begin errors++; $display("FAIL postrst_pc got %h want 3000", pc0); end
    checks++; if (cnt0 !== 16'd1) begin errors++; $display("FAIL postrst_cnt got %0d want 1", cnt0); end
  endtask

  initial begin
    test_reset();
    test_write();
    test_branch();
    test_align();
    test_sel_err();
    test_back_to_back();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout reached without completing");
    $fatal(1, "timeout");
  end

endmodule
